// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: shared state encoding, X-mux select codes and default sample count for the input sequencer.
package nn_seq_pkg;
    typedef enum logic [2:0] {IDLE, CLR, X1, X2, BIAS, ACT, DONE} state_t;
    localparam logic [1:0] SEL_X1  = 2'b00;
    localparam logic [1:0] SEL_X2  = 2'b01;
    localparam logic [1:0] SEL_ONE = 2'b10;
    localparam logic [1:0] SEL_INV = 2'b11;
    localparam int DEF_NUM_SAMPLES = 4;
endpackage

// File: rtl/nn_input_sequencer_counter.sv
// nn_sample_counter: sample index within a pass, with synchronous clear/increment and a last-sample flag.
module nn_sample_counter
    import nn_seq_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              last
);
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (inc)   count <= count + 1'b1;
    end
    assign last = count == ADDR_W'(NUM_SAMPLES - 1);
endmodule

// File: rtl/nn_input_sequencer.sv
// nn_input_sequencer: per-sample CLR/X1/X2/(BIAS)/ACT sequencing of a perceptron datapath with stall hold.
// Build option: NN_SEQ_BIAS_EN adds the BIAS step (constant-1 input) to every sample.
module nn_input_sequencer
    import nn_seq_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int ADDR_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic [1:0]        mux_sel,
    output logic [1:0]        w_idx,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              act_en,
    output logic              busy,
    output logic              done
);
    state_t     state, nxt;
    logic       hold, last;
    logic [1:0] sel;

    assign hold = stall && state != IDLE && state != DONE;

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:    nxt = start ? CLR : IDLE;
            CLR:     nxt = X1;
            X1:      nxt = X2;
`ifdef NN_SEQ_BIAS_EN
            X2:      nxt = BIAS;
            BIAS:    nxt = ACT;
`else
            X2:      nxt = ACT;
`endif
            ACT:     nxt = last ? DONE : CLR;
            default: nxt = IDLE;
        endcase
        if (hold) nxt = state;
        sel = nxt == X2 ? SEL_X2 : nxt == BIAS ? SEL_ONE : SEL_X1;
    end

    nn_sample_counter #(.NUM_SAMPLES(NUM_SAMPLES), .ADDR_W(ADDR_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state == IDLE && start) || state == DONE),
        .inc   (state == ACT && !hold && !last),
        .count (sample_addr),
        .last  (last)
    );

    // A held step keeps its select but drops its strobes, so it is performed exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mux_sel <= SEL_X1;
            w_idx   <= 2'd0;
            acc_clr <= 1'b0;
            acc_en  <= 1'b0;
            act_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            mux_sel <= sel;
            w_idx   <= sel;
            acc_clr <= !hold && nxt == CLR;
            acc_en  <= !hold && (nxt == X1 || nxt == X2 || nxt == BIAS);
            act_en  <= !hold && nxt == ACT;
            busy    <= nxt != IDLE;
            done    <= nxt == DONE;
        end
    end
endmodule

// File: tb/tb_nn_input_sequencer.sv
// tb_nn_input_sequencer: directed pass traces against hand-computed cycle timings (with or without NN_SEQ_BIAS_EN).
module tb_nn_input_sequencer;
`ifdef NN_SEQ_BIAS_EN
    localparam int SPS = 5;
    localparam int DONE_C = 21;
    localparam int DONE1_C = 6;
`else
    localparam int SPS = 4;
    localparam int DONE_C = 17;
    localparam int DONE1_C = 5;
`endif
    localparam int N = 32;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stall = 1'b0;
    logic [1:0] mux_sel, w_idx, mux_sel1, w_idx1;
    logic [3:0] sample_addr, sample_addr1;
    logic acc_clr, acc_en, act_en, busy, done;
    logic acc_clr1, acc_en1, act_en1, busy1, done1;

    int tests = 0, fails = 0;
    int tm[N], tw[N], ten[N], tact[N], tdone[N], tbusy[N], tclr[N], taddr[N], tdone1[N];

    nn_input_sequencer #(.NUM_SAMPLES(4), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .mux_sel(mux_sel), .w_idx(w_idx), .sample_addr(sample_addr),
        .acc_clr(acc_clr), .acc_en(acc_en), .act_en(act_en), .busy(busy), .done(done)
    );

    nn_input_sequencer #(.NUM_SAMPLES(1), .ADDR_W(4)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .mux_sel(mux_sel1), .w_idx(w_idx1), .sample_addr(sample_addr1),
        .acc_clr(acc_clr1), .acc_en(acc_en1), .act_en(act_en1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle k covers posedge k..k+1; start is high in cycle 0, outputs are sampled 1 time unit after each edge.
    task automatic run(input int stall_at, input int stall_len, input int restart_at, input int rst_at);
        for (int k = 0; k < N; k++) begin
            @(posedge clk);
            #1;
            tm[k] = int'(mux_sel);
            tw[k] = int'(w_idx);
            ten[k] = int'(acc_en);
            tact[k] = int'(act_en);
            tdone[k] = int'(done);
            tbusy[k] = int'(busy);
            tclr[k] = int'(acc_clr);
            taddr[k] = int'(sample_addr);
            tdone1[k] = int'(done1);
            start = (k == 0) || (k == restart_at);
            stall = (k >= stall_at) && (k < stall_at + stall_len);
            rst = (k == rst_at);
        end
        start = 1'b0;
        stall = 1'b0;
        rst = 1'b0;
    endtask

    function automatic int count_done();
        int c = 0;
        for (int k = 0; k < N; k++) c += tdone[k];
        return c;
    endfunction

    initial begin
        int c3, c2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mux", int'(mux_sel), 0);
        chk("rst_addr", int'(sample_addr), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;

        run(N, 0, -1, -1);
        chk("idle_c0_busy", tbusy[0], 0);
        chk("clr_c1", tclr[1], 1);
        chk("x1_mux", tm[2], 0);
        chk("x1_en", ten[2], 1);
        chk("x2_mux", tm[3], 1);
        chk("x2_widx", tw[3], 1);
        chk("x2_en", ten[3], 1);
`ifdef NN_SEQ_BIAS_EN
        chk("bias_mux", tm[4], 2);
        chk("bias_widx", tw[4], 2);
        chk("bias_en", ten[4], 1);
`else
        chk("act_mux", tm[4], 0);
`endif
        for (int s = 0; s < 4; s++) begin
            chk($sformatf("act_en_s%0d", s), tact[SPS * (s + 1)], 1);
            chk($sformatf("act_addr_s%0d", s), taddr[SPS * (s + 1)], s);
            chk($sformatf("act_pre_s%0d", s), tact[SPS * (s + 1) - 1], 0);
        end
        chk("done_cycle", tdone[DONE_C], 1);
        chk("done_pre", tdone[DONE_C - 1], 0);
        chk("done_once", count_done(), 1);
        chk("post_busy", tbusy[DONE_C + 1], 0);
        chk("post_addr", taddr[DONE_C + 1], 0);
        c3 = 0;
        c2 = 0;
        for (int k = 0; k < N; k++) begin
            c3 += int'(tm[k] == 3);
            c2 += int'(tm[k] == 2);
        end
        chk("mux_never_11", c3, 0);
`ifndef NN_SEQ_BIAS_EN
        chk("mux_never_10", c2, 0);
`else
        chk("mux_10_count", c2, 4);
`endif
        chk("ns1_done", tdone1[DONE1_C], 1);
        chk("ns1_done_pre", tdone1[DONE1_C - 1], 0);

        run(SPS + 3, 3, -1, -1);
        for (int k = SPS + 4; k <= SPS + 6; k++) begin
            chk($sformatf("stall_mux_c%0d", k), tm[k], 1);
            chk($sformatf("stall_en_c%0d", k), ten[k], 0);
            chk($sformatf("stall_addr_c%0d", k), taddr[k], 1);
        end
`ifdef NN_SEQ_BIAS_EN
        chk("stall_resume_mux", tm[SPS + 7], 2);
        chk("stall_resume_en", ten[SPS + 7], 1);
`else
        chk("stall_resume_act", tact[SPS + 7], 1);
`endif
        chk("stall_done_late", tdone[DONE_C + 3], 1);
        chk("stall_done_once", count_done(), 1);

        run(N, 0, 7, -1);
        chk("restart_done", tdone[DONE_C], 1);
        chk("restart_done_once", count_done(), 1);

        run(N, 0, -1, 9);
        chk("rst_mid_busy_before", tbusy[9], 1);
        chk("rst_mid_busy", tbusy[10], 0);
        chk("rst_mid_mux", tm[10], 0);
        chk("rst_mid_widx", tw[10], 0);
        chk("rst_mid_en", ten[10] + tact[10] + tclr[10], 0);
        chk("rst_mid_addr", taddr[10], 0);
        chk("rst_mid_no_done", count_done(), 0);

        run(N, 0, -1, -1);
        chk("after_rst_addr_c1", taddr[1], 0);
        chk("after_rst_act0_addr", taddr[SPS], 0);
        chk("after_rst_done", tdone[DONE_C], 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
